// File: rtl/gbe_pkt_pkg.sv
// Shared types and helpers for the 10GbE transmit packetizer.
// Holds the FSM state encoding and the header word layout.
package gbe_pkt_pkg;

    localparam int HDR_MCNT_W = 48;
    localparam int SRC_ID_W   = 16;
    localparam int HDR_W      = HDR_MCNT_W + SRC_ID_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } state_t;

    // Header layout: packet counter in the upper bits, source id in the low 16.
    function automatic logic [HDR_W-1:0] pack_header(
        input logic [HDR_MCNT_W-1:0] mcnt,
        input logic [SRC_ID_W-1:0]   src_id
    );
        return {mcnt, src_id};
    endfunction

endpackage

// File: rtl/gbe_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// rd_data always shows the oldest stored word while the FIFO is not empty.
module gbe_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/gbe_tx_packetizer.sv
// Buffers a 64-bit sample stream and emits header + PAYLOAD_WORDS data words
// per UDP packet, rotating the destination IP round-robin over NUM_DEST nodes.
module gbe_tx_packetizer
    import gbe_pkt_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int PAYLOAD_WORDS = 128,
    parameter int NUM_DEST      = 2,
    parameter int FIFO_DEPTH    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sync,
    input  logic [15:0]           src_id,
    input  logic [31:0]           dest_ip_base,
    input  logic [15:0]           dest_port,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_end_of_frame,
    output logic [31:0]           tx_dest_ip,
    output logic [15:0]           tx_dest_port,
    input  logic                  tx_afull,
    input  logic                  tx_overflow,
    output logic [31:0]           pkt_count,
    output logic [31:0]           drop_count,
    output logic [15:0]           ovf_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int WC_W  = $clog2(PAYLOAD_WORDS + 1);
    localparam int DI_W  = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;

    logic [DATA_WIDTH-1:0] fifo_data;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    state_t                state;
    state_t                state_next;
    logic                  start;
    logic                  emit;
    logic                  done;

    logic [WC_W-1:0]       wcnt;
    logic [HDR_MCNT_W-1:0] mcnt;
    logic [DI_W-1:0]       dest_idx;
    logic [DI_W-1:0]       dest_idx_inc;
    logic                  sync_pend;

    gbe_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data (in_data),
        .rd_en   (emit),
        .rd_data (fifo_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign dest_idx_inc = (dest_idx == DI_W'(NUM_DEST - 1)) ? '0 : dest_idx + 1'b1;

    // tx_* are registered, so each state's word becomes visible one cycle later:
    // the header is on the pins during HDR, and the EOF word during the last PAY cycle.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        emit       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (en && (fifo_count >= CNT_W'(PAYLOAD_WORDS)) && !tx_afull) begin
                    start      = 1'b1;
                    state_next = HDR;
                end
            end
            HDR: begin
                state_next = PAY;
                emit       = !tx_afull && !fifo_empty;
            end
            PAY: begin
                if (wcnt == WC_W'(PAYLOAD_WORDS)) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else begin
                    emit = !tx_afull && !fifo_empty;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid        <= 1'b0;
            tx_data         <= '0;
            tx_end_of_frame <= 1'b0;
            tx_dest_ip      <= '0;
            tx_dest_port    <= '0;
            wcnt            <= '0;
            mcnt            <= '0;
            dest_idx        <= '0;
            sync_pend       <= 1'b0;
            pkt_count       <= '0;
            drop_count      <= '0;
            ovf_count       <= '0;
        end else begin
            tx_valid        <= start || emit;
            tx_end_of_frame <= emit && (wcnt == WC_W'(PAYLOAD_WORDS - 1));

            if (start) begin
                tx_data      <= pack_header(mcnt, src_id);
                tx_dest_ip   <= dest_ip_base + 32'(dest_idx);
                tx_dest_port <= dest_port;
                wcnt         <= '0;
            end else if (emit) begin
                tx_data <= fifo_data;
                wcnt    <= wcnt + 1'b1;
            end

            // A sync seen mid-packet is deferred so it overrides the end-of-packet advance.
            if (done) begin
                pkt_count <= pkt_count + 1'b1;
                if (in_sync || sync_pend) begin
                    mcnt      <= '0;
                    dest_idx  <= '0;
                    sync_pend <= 1'b0;
                end else begin
                    mcnt     <= mcnt + 1'b1;
                    dest_idx <= dest_idx_inc;
                end
            end else if (in_sync) begin
                if (state == IDLE) begin
                    mcnt     <= '0;
                    dest_idx <= '0;
                end else begin
                    sync_pend <= 1'b1;
                end
            end

            if (in_valid && fifo_full) begin
                drop_count <= drop_count + 1'b1;
            end

            if (tx_overflow && (ovf_count != 16'hFFFF)) begin
                ovf_count <= ovf_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gbe_tx_packetizer.sv
// Directed bench for gbe_tx_packetizer: PAYLOAD_WORDS=4, NUM_DEST=2, FIFO_DEPTH=16.
module tb_gbe_tx_packetizer;

    localparam int          PW   = 4;
    localparam int          ND   = 2;
    localparam int          FD   = 16;
    localparam logic [31:0] IP0  = 32'hC0A80514;
    localparam logic [31:0] IP1  = 32'hC0A80515;
    localparam logic [15:0] SRC  = 16'h00AB;
    localparam logic [15:0] PORT = 16'd5000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_sync = 1'b0;
    logic [15:0] src_id = SRC;
    logic [31:0] dest_ip_base = IP0;
    logic [15:0] dest_port = PORT;
    logic        tx_afull = 1'b0;
    logic        tx_overflow = 1'b0;
    logic        tx_valid;
    logic [63:0] tx_data;
    logic        tx_end_of_frame;
    logic [31:0] tx_dest_ip;
    logic [15:0] tx_dest_port;
    logic [31:0] pkt_count;
    logic [31:0] drop_count;
    logic [15:0] ovf_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Captured and expected words: {eof, dest_ip, data}.
    logic [96:0] cap_q[$];
    int          cap_cyc[$];
    logic [96:0] exp_q[$];

    gbe_tx_packetizer #(
        .DATA_WIDTH    (64),
        .PAYLOAD_WORDS (PW),
        .NUM_DEST      (ND),
        .FIFO_DEPTH    (FD)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_sync         (in_sync),
        .src_id          (src_id),
        .dest_ip_base    (dest_ip_base),
        .dest_port       (dest_port),
        .tx_valid        (tx_valid),
        .tx_data         (tx_data),
        .tx_end_of_frame (tx_end_of_frame),
        .tx_dest_ip      (tx_dest_ip),
        .tx_dest_port    (tx_dest_port),
        .tx_afull        (tx_afull),
        .tx_overflow     (tx_overflow),
        .pkt_count       (pkt_count),
        .drop_count      (drop_count),
        .ovf_count       (ovf_count)
    );

    // Clock / reset
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid) begin
                cap_q.push_back({tx_end_of_frame, tx_dest_ip, tx_data});
                cap_cyc.push_back(cyc);
                checks++;
                if (tx_dest_port !== PORT) begin
                    failures++;
                    $display("FAIL dest_port actual=%0h required=%0h", tx_dest_port, PORT);
                end
            end
            if (tx_end_of_frame) begin
                checks++;
                if (tx_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL eof_without_valid actual=%b required=1", tx_valid);
                end
            end
        end
    end

    function automatic logic [96:0] ent(input logic eof, input logic [31:0] ip, input logic [63:0] d);
        return {eof, ip, d};
    endfunction

    function automatic logic [96:0] hdr(input logic [47:0] m, input logic [31:0] ip);
        return {1'b0, ip, m, SRC};
    endfunction

    // Driver tasks
    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        in_valid = 1'b0;
        in_sync = 1'b0;
        tx_afull = 1'b0;
        tx_overflow = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cap_q.delete();
        cap_cyc.delete();
        exp_q.delete();
    endtask

    task automatic push(input logic [63:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data = first + 64'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_pkts(input int n);
        for (int k = 0; k < 500 && pkt_count < 32'(n); k++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_word(input logic [63:0] v, output bit found);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (tx_valid && tx_data == v) found = 1'b1;
        end
    endtask

    // Scenarios
    task automatic test_reset();
        logic [63:0] obs [8];
        string       nm  [8];
        do_reset();
        obs[0] = 64'(tx_valid);        nm[0] = "tx_valid";
        obs[1] = tx_data;              nm[1] = "tx_data";
        obs[2] = 64'(tx_end_of_frame); nm[2] = "tx_eof";
        obs[3] = 64'(tx_dest_ip);      nm[3] = "tx_dest_ip";
        obs[4] = 64'(tx_dest_port);    nm[4] = "tx_dest_port";
        obs[5] = 64'(pkt_count);       nm[5] = "pkt_count";
        obs[6] = 64'(drop_count);      nm[6] = "drop_count";
        obs[7] = 64'(ovf_count);       nm[7] = "ovf_count";
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs[i] !== 64'd0) begin
                failures++;
                $display("FAIL reset_%s actual=%0h required=0", nm[i], obs[i]);
            end
        end
    endtask

    task automatic test_basic();
        do_reset();
        en = 1'b1;
        push(64'd1, 8);
        wait_pkts(2);
        exp_q.push_back(hdr(48'd0, IP0));
        for (int i = 1; i <= 4; i++) exp_q.push_back(ent(i == 4, IP0, 64'(i)));
        exp_q.push_back(hdr(48'd1, IP1));
        for (int i = 5; i <= 8; i++) exp_q.push_back(ent(i == 8, IP1, 64'(i)));
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL basic_words actual=%0d required=%0d", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL basic_word%0d actual=%h required=%h", i, cap_q[i], exp_q[i]);
            end
        end
        checks++;
        if (pkt_count !== 32'd2) begin
            failures++;
            $display("FAIL basic_pkt_count actual=%0d required=2", pkt_count);
        end
    endtask

    task automatic test_backpressure();
        bit found;
        int gap;
        do_reset();
        en = 1'b1;
        push(64'd1, 4);
        wait_word(64'd2, found);
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL bp_word2_seen actual=0 required=1");
        end
        tx_afull = 1'b1;
        gap = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (!tx_valid) gap++;
        end
        tx_afull = 1'b0;
        checks++;
        if (gap != 3) begin
            failures++;
            $display("FAIL bp_stall_cycles actual=%0d required=3", gap);
        end
        @(negedge clk);
        checks++;
        if (!(tx_valid === 1'b1 && tx_data === 64'd3)) begin
            failures++;
            $display("FAIL bp_resume actual=%b/%0h required=1/3", tx_valid, tx_data);
        end
        wait_pkts(1);
        exp_q.push_back(hdr(48'd0, IP0));
        for (int i = 1; i <= 4; i++) exp_q.push_back(ent(i == 4, IP0, 64'(i)));
        checks++;
        if (cap_q.size() != 5) begin
            failures++;
            $display("FAIL bp_valid_cycles actual=%0d required=5", cap_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL bp_word%0d actual=%h required=%h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_overflow_sync();
        bit found;
        do_reset();
        push(64'd1, 20);
        repeat (2) @(negedge clk);
        checks++;
        if (drop_count !== 32'd4) begin
            failures++;
            $display("FAIL ovf_drop_count actual=%0d required=4", drop_count);
        end
        checks++;
        if (cap_q.size() != 0) begin
            failures++;
            $display("FAIL ovf_tx_while_disabled actual=%0d required=0", cap_q.size());
        end
        en = 1'b1;
        wait_word(64'd9, found);
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL sync_word9_seen actual=0 required=1");
        end
        in_sync = 1'b1;
        @(negedge clk);
        in_sync = 1'b0;
        wait_pkts(4);
        exp_q.push_back(hdr(48'd0, IP0));
        for (int i = 1; i <= 4; i++) exp_q.push_back(ent(i == 4, IP0, 64'(i)));
        exp_q.push_back(hdr(48'd1, IP1));
        for (int i = 5; i <= 8; i++) exp_q.push_back(ent(i == 8, IP1, 64'(i)));
        exp_q.push_back(hdr(48'd2, IP0));
        for (int i = 9; i <= 12; i++) exp_q.push_back(ent(i == 12, IP0, 64'(i)));
        exp_q.push_back(hdr(48'd0, IP0));
        for (int i = 13; i <= 16; i++) exp_q.push_back(ent(i == 16, IP0, 64'(i)));
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL ovf_words actual=%0d required=%0d", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL ovf_word%0d actual=%h required=%h", i, cap_q[i], exp_q[i]);
            end
        end
        if (cap_cyc.size() >= 20) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (cap_cyc[5*k+5] - cap_cyc[5*k+4] != 2) begin
                    failures++;
                    $display("FAIL b2b_gap%0d actual=%0d required=2", k, cap_cyc[5*k+5] - cap_cyc[5*k+4]);
                end
            end
        end
        checks++;
        if (pkt_count !== 32'd4) begin
            failures++;
            $display("FAIL ovf_pkt_count actual=%0d required=4", pkt_count);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        do_reset();
        en = 1'b1;
        push(64'd1, 4);
        wait_word(64'd2, found);
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rstmid_word2_seen actual=0 required=1");
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || tx_end_of_frame !== 1'b0 || tx_dest_ip !== 32'd0) begin
            failures++;
            $display("FAIL rstmid_tx actual=%b/%b/%h required=0/0/0", tx_valid, tx_end_of_frame, tx_dest_ip);
        end
        checks++;
        if (pkt_count !== 32'd0 || drop_count !== 32'd0 || ovf_count !== 16'd0) begin
            failures++;
            $display("FAIL rstmid_counters actual=%0d/%0d/%0d required=0/0/0", pkt_count, drop_count, ovf_count);
        end
        rst = 1'b0;
        cap_q.delete();
        cap_cyc.delete();
        push(64'd10, 3);
        repeat (10) @(negedge clk);
        checks++;
        if (cap_q.size() != 0) begin
            failures++;
            $display("FAIL rstmid_early_start actual=%0d required=0", cap_q.size());
        end
        push(64'd13, 1);
        wait_pkts(1);
        exp_q.push_back(hdr(48'd0, IP0));
        for (int i = 10; i <= 13; i++) exp_q.push_back(ent(i == 13, IP0, 64'(i)));
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rstmid_words actual=%0d required=%0d", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rstmid_word%0d actual=%h required=%h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        tx_overflow = 1'b1;
        repeat (100) @(negedge clk);
        checks++;
        if (ovf_count !== 16'd100) begin
            failures++;
            $display("FAIL ovf_count_100 actual=%0d required=100", ovf_count);
        end
        en = 1'b1;
        push(64'd1, 8);
        wait_pkts(2);
        exp_q.push_back(hdr(48'd0, IP0));
        for (int i = 1; i <= 4; i++) exp_q.push_back(ent(i == 4, IP0, 64'(i)));
        exp_q.push_back(hdr(48'd1, IP1));
        for (int i = 5; i <= 8; i++) exp_q.push_back(ent(i == 8, IP1, 64'(i)));
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL sat_words actual=%0d required=%0d", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL sat_word%0d actual=%h required=%h", i, cap_q[i], exp_q[i]);
            end
        end
        repeat (70000) @(negedge clk);
        checks++;
        if (ovf_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL ovf_count_sat actual=%0h required=ffff", ovf_count);
        end
        tx_overflow = 1'b0;
        checks++;
        if (pkt_count !== 32'd2) begin
            failures++;
            $display("FAIL sat_pkt_count actual=%0d required=2", pkt_count);
        end
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow_sync();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gbe_tx_packetizer.md
Name: gbe_tx_packetizer

Overview:
- Parametrised transmit-side packetizer that feeds the kat_ten_gb_eth fabric TX interface.
- Buffers a continuous 64-bit sample stream and emits fixed-length UDP payloads. Each payload is one header word followed by PAYLOAD_WORDS data words.
- Distributes packets round-robin across NUM_DEST destination IPs, for example one per GPU node.
- Applies tx_afull backpressure and counts dropped input words and core overflows.

Parameters:
- DATA_WIDTH, 64: stream and tx_data width. Must be 64.
- PAYLOAD_WORDS, 128: data words per packet. Range 2..1024.
- NUM_DEST, 2: number of destinations. Range 1..16.
- FIFO_DEPTH, 1024: input buffer depth in words. Must be a power of 2 and at least 2*PAYLOAD_WORDS.

Ports:
- clk  in  1  fabric clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  transmit enable.
- in_valid  in  1  input word strobe.
- in_data  in  64  input sample word.
- in_sync  in  1  one-cycle pulse; restarts packet counter.
- src_id  in  16  source identifier, placed in the header.
- dest_ip_base  in  32  IP address of destination 0.
- dest_port  in  16  UDP port for all destinations.
- tx_valid  out  1  word strobe to the core.
- tx_data  out  64  word to the core.
- tx_end_of_frame  out  1  marks the last word of a packet.
- tx_dest_ip  out  32  destination IP, held for the whole packet.
- tx_dest_port  out  16  destination port, held for the whole packet.
- tx_afull  in  1  core TX buffer almost full.
- tx_overflow  in  1  core TX overflow indication.
- pkt_count  out  32  packets completed since reset.
- drop_count  out  32  input words dropped because the FIFO was full.
- ovf_count  out  16  cycles with tx_overflow high; saturates.

Behaviour:
- Reset (synchronous, rst high at a clk edge) clears everything:
  - All outputs go to 0. tx_dest_ip=0, tx_dest_port=0.
  - FIFO emptied, state=IDLE, dest_idx=0, mcnt=0.
- Input FIFO:
  - Write when in_valid and not full.
  - in_valid while full: the word is discarded and drop_count increments (wraps at 2^32).
  - Writing and reading in the same cycle is legal and leaves the occupancy unchanged.
  - Reads are first-word-fall-through.
- State machine IDLE -> HDR -> PAY -> IDLE:
  - IDLE -> HDR: when en=1, FIFO occupancy >= PAYLOAD_WORDS and tx_afull=0, all sampled in the same cycle. On that transition, latch tx_dest_ip = dest_ip_base + dest_idx (32-bit wrap) and tx_dest_port = dest_port.
  - HDR: drive tx_valid=1 for one cycle with tx_data = {mcnt[47:0], src_id}. Go to PAY.
  - PAY: each cycle with tx_afull=0, pop one FIFO word, tx_valid=1, tx_data = word.
  - PAY stall: while tx_afull=1, tx_valid=0 and no pop. The word counter holds.
  - Last (PAYLOAD_WORDS-th) word: tx_end_of_frame=1 in the same cycle. Then return to IDLE, increment pkt_count and mcnt (48-bit wrap), and set dest_idx = (dest_idx+1) mod NUM_DEST.
- Word counts and outputs:
  - A packet is exactly PAYLOAD_WORDS+1 tx_valid cycles.
  - tx_end_of_frame is never high without tx_valid.
  - tx_dest_ip and tx_dest_port are stable from HDR through the EOF word.
  - All tx_* outputs are registered. The header appears on tx_data the cycle after the IDLE decision.
- Control inputs:
  - tx_afull during HDR is ignored; the core guarantees headroom for one word.
  - en deasserted mid-packet: the current packet completes; no new packet starts.
  - in_sync: mcnt is set to 0 and dest_idx to 0, taking effect on the next packet header. A packet already in progress is unaffected.
  - in_sync in the same cycle as the EOF increment: in_sync wins (mcnt=0, dest_idx=0).
  - src_id, dest_ip_base and dest_port are sampled only at the IDLE -> HDR transition.
- Counters:
  - ovf_count increments each cycle tx_overflow=1 and saturates at 16'hFFFF.
  - tx_overflow does not affect sequencing.
- Back-to-back packets: a new packet may start the cycle after EOF. The minimum gap is one IDLE cycle with tx_valid=0.

Decomposition:
- Shared package gbe_pkt_pkg holds:
  - state enum {IDLE, HDR, PAY};
  - HDR_MCNT_W = 48 and SRC_ID_W = 16;
  - the header packing function.
- One sub-module, gbe_sync_fifo: parametrised width and depth; FWFT; outputs count, full and empty; synchronous active-high rst.
- The packetizer instantiates the FIFO plus its FSM and counters.

Test Plan:
Bench parameters: PAYLOAD_WORDS=4, NUM_DEST=2, FIFO_DEPTH=16, dest_ip_base=32'hC0A80514, src_id=16'h00AB.
- Basic stream: 8 consecutive words 1..8, en=1, tx_afull=0 -> packet 1 is header 64'h0000_0000_0000_00AB, then 1,2,3,4 with EOF on 4, ip C0A80514. Packet 2 is header 64'h0000_0000_0001_00AB, then 5..8, ip C0A80515. pkt_count=2.
- Backpressure: tx_afull high for 3 cycles after the second payload word -> tx_valid low for exactly those 3 cycles. Total tx_valid cycles = 5. Data order unchanged.
- Overflow input: 20 in_valid words with en=0 -> FIFO holds 16 and drop_count=4. Then en=1 -> 4 packets of words 1..16 are emitted.
- Sync: in_sync pulsed during packet 3 payload -> packet 3 header keeps mcnt=2. Packet 4 header has mcnt=0 and ip C0A80514.
- Reset mid-packet: rst high during the second payload word -> the next cycle has tx_valid=0 and all counters 0. After release, packets start only once 4 new words have arrived.
- Saturation: hold tx_overflow high for 70000 cycles -> ovf_count=16'hFFFF. Packet sequencing is unaffected.
